alu_selftest: RTL and testbench
===============================

ALU_SELFTEST -- requirements
Module: alu_selftest

Interface
REQ-001 Parameter: SETTLE, 1, wait cycles between driving a vector and sampling the response (legal 0..15).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin exhaustive sweep; sampled only in IDLE or DONE.
REQ-005 dut_ctrl  output  1  operation driven to the 4-bit add/sub unit (0 add, 1 subtract).
REQ-006 dut_a  output  4  operand A to unit.
REQ-007 dut_b  output  4  operand B to unit.
REQ-008 dut_s  input  4  sum/difference returned by unit.
REQ-009 dut_c0  input  1  carry-out returned by unit.
REQ-010 busy  output  1  sweep in progress.
REQ-011 done  output  1  sweep complete; held until next start or rst.
REQ-012 pass  output  1  valid with done; 1 iff err_count == 0.
REQ-013 err_count  output  10  number of mismatching vectors in current/last sweep.
REQ-014 fail_valid  output  1  at least one mismatch recorded.
REQ-015 fail_vec  output  9  index {A,B,Ctrl} of first mismatching vector.
REQ-016 fail_got  output  5  {dut_c0,dut_s} captured at first mismatch.

Function
REQ-017 Vector index v = {A[3:0],B[3:0],Ctrl}, swept 0..511 ascending (Ctrl fastest, A slowest).
REQ-018 Expected result: {C0,S} = A + (B xor {4{Ctrl}}) + Ctrl, 5-bit; C0 is raw carry-out (subtract: C0=1 means A >= B, no borrow).
REQ-019 FSM states IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-020 IDLE/DONE + start=1 -> DRIVE; same edge loads v=0 onto dut_*, clears err_count, fail_valid, fail_vec, fail_got, done, pass.
REQ-021 DRIVE lasts 1 cycle -> WAIT (or -> CHECK when SETTLE=0); WAIT lasts exactly SETTLE cycles -> CHECK.
REQ-022 CHECK lasts 1 cycle: compares {dut_c0,dut_s} with expected for v; on mismatch err_count increments and, if fail_valid=0, fail_valid/fail_vec/fail_got are captured.
REQ-023 CHECK with v<511 -> DRIVE, loading v+1 onto dut_* on that edge; CHECK with v=511 -> DONE.
REQ-024 dut_* hold constant from the edge entering DRIVE through CHECK of the same vector.
REQ-025 Sweep length: exactly 512*(SETTLE+2) rising edges from the start edge to the edge setting done=1.
REQ-026 busy=1 in DRIVE/WAIT/CHECK only; done=1 in DONE only; pass registered on entry to DONE.
REQ-027 start while busy=1 is ignored; start held high in DONE restarts immediately.
REQ-028 err_count never wraps (max 512 fits 10 bits); counting and first-fail capture in the same CHECK cycle are consistent (err_count=1 with fail_valid=1).
REQ-029 In DONE, dut_* keep vector 511.

Reset
REQ-030 rst=1 at any edge, including mid-sweep, forces IDLE; dut_ctrl/dut_a/dut_b=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, fail_vec=0, fail_got=0.
REQ-031 rst has priority over start; start sampled on the first edge with rst=0.

Structure
REQ-032 Shared package holds NUM_VECTORS=512, VEC_W=9, FSM state encoding, and the expected-result function.
REQ-033 One sub-module addsub4b_model: combinational golden model (Ctrl, A, B -> C0, S) per REQ-018.

Verification
REQ-034 Correct unit attached, SETTLE=1, pulse start -> done after 1536 edges, pass=1, err_count=0, fail_valid=0.
REQ-035 Unit with S[0] stuck-at-0 -> err_count=256, fail_vec=2 (A=0,B=1,add), fail_got=5'b00000, pass=0.
REQ-036 Unit with C0 stuck-at-0 -> err_count=256 (120 add + 136 sub), fail_vec=1 (A=0,B=0,sub), fail_got=5'b00000.
REQ-037 SETTLE=0 and SETTLE=3, correct unit -> done after 1024 and 2560 edges respectively; dut_* stable across each DRIVE..CHECK window.
REQ-038 rst asserted at vector 100 -> next edge IDLE, all outputs zero; restart completes with pass=1.
REQ-039 start pulsed during busy -> ignored (sweep length unchanged); start in DONE -> counters cleared, new sweep begins.

Source files
------------

// File: rtl/alu_selftest_pkg.sv
// Shared definitions for the 4-bit add/sub unit self-test.
//   NUM_VECTORS / VEC_W : size and width of the exhaustive vector space {A,B,Ctrl}
//   ERR_W               : width of the mismatch counter (holds up to NUM_VECTORS)
//   state_e             : sweep controller state encoding
//   addsub_expected()   : golden {C0,S} for one vector
package alu_selftest_pkg;

    localparam int NUM_VECTORS = 512;
    localparam int VEC_W       = 9;
    localparam int ERR_W       = 10;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Subtract is A + ~B + 1, so C0 is the raw carry-out: 1 means no borrow.
    function automatic logic [4:0] addsub_expected(input logic       ctrl,
                                                   input logic [3:0] a,
                                                   input logic [3:0] b);
        return {1'b0, a} + {1'b0, b ^ {4{ctrl}}} + {4'd0, ctrl};
    endfunction

endpackage

// File: rtl/alu_selftest_addsub4b_model.sv
// Combinational golden model of the 4-bit add/sub unit.
//   ctrl : 0 add, 1 subtract
//   a, b : operands
//   c0   : raw carry-out
//   s    : 4-bit sum/difference
module addsub4b_model
    import alu_selftest_pkg::*;
(
    input  logic       ctrl,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       c0,
    output logic [3:0] s
);

    assign {c0, s} = addsub_expected(ctrl, a, b);

endmodule

// File: rtl/alu_selftest.sv
// Exhaustive self-test controller for an external 4-bit add/sub unit.
// Sweeps every {A,B,Ctrl} vector, waits SETTLE cycles, compares the unit's
// response against the golden model and records the error count and the
// first failing vector.
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a sweep (accepted in IDLE or DONE only)
//   dut_ctrl/dut_a/dut_b: vector driven to the unit
//   dut_s/dut_c0        : unit response
//   busy, done, pass    : sweep status
//   err_count           : mismatches in the current/last sweep
//   fail_valid/fail_vec/fail_got : first mismatch record
//
// state    | meaning
// ---------+-----------------------------------------------------
// ST_IDLE  | after reset, waiting for start
// ST_DRIVE | vector just applied to the unit (1 cycle)
// ST_WAIT  | settle time, SETTLE cycles via down-counter
// ST_CHECK | compare response with golden model (1 cycle)
// ST_DONE  | sweep finished, results held, waiting for start
module alu_selftest
    import alu_selftest_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             dut_ctrl,
    output logic [3:0]       dut_a,
    output logic [3:0]       dut_b,
    input  logic [3:0]       dut_s,
    input  logic             dut_c0,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_valid,
    output logic [VEC_W-1:0] fail_vec,
    output logic [4:0]       fail_got
);

    // Counter reload so that WAIT lasts exactly SETTLE cycles (terminal count 0).
    localparam logic [3:0] WAIT_LOAD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_e           state_q,      state_d;
    logic [VEC_W-1:0] vec_q,        vec_d;
    logic [3:0]       wait_cnt_q,   wait_cnt_d;
    logic [ERR_W-1:0] err_count_q,  err_count_d;
    logic             fail_valid_q, fail_valid_d;
    logic [VEC_W-1:0] fail_vec_q,   fail_vec_d;
    logic [4:0]       fail_got_q,   fail_got_d;
    logic             pass_q,       pass_d;

    logic       exp_c0;
    logic [3:0] exp_s;
    logic       mismatch;

    addsub4b_model u_model (
        .ctrl (vec_q[0]),
        .a    (vec_q[8:5]),
        .b    (vec_q[4:1]),
        .c0   (exp_c0),
        .s    (exp_s)
    );

    assign mismatch = ({dut_c0, dut_s} != {exp_c0, exp_s});

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        wait_cnt_d   = wait_cnt_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        fail_got_d   = fail_got_q;
        pass_d       = pass_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_DRIVE;
                    vec_d        = '0;
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    fail_vec_d   = '0;
                    fail_got_d   = '0;
                    pass_d       = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (SETTLE == 0) begin
                    state_d = ST_CHECK;
                end else begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = WAIT_LOAD;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_count_d = err_count_q + 1'b1;
                    if (!fail_valid_q) begin
                        fail_valid_d = 1'b1;
                        fail_vec_d   = vec_q;
                        fail_got_d   = {dut_c0, dut_s};
                    end
                end
                if (vec_q == LAST_VEC) begin
                    state_d = ST_DONE;
                    // Uses this cycle's count so a failure on the last vector counts.
                    pass_d  = (err_count_d == '0);
                end else begin
                    state_d = ST_DRIVE;
                    vec_d   = vec_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            wait_cnt_q   <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            fail_got_q   <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            wait_cnt_q   <= wait_cnt_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            fail_got_q   <= fail_got_d;
            pass_q       <= pass_d;
        end
    end

    assign dut_ctrl   = vec_q[0];
    assign dut_b      = vec_q[4:1];
    assign dut_a      = vec_q[8:5];
    assign busy       = (state_q == ST_DRIVE) || (state_q == ST_WAIT) || (state_q == ST_CHECK);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;
    assign fail_got   = fail_got_q;

endmodule

// File: tb/tb_alu_selftest.sv
// Bench for alu_selftest: three instances (SETTLE = 0, 1, 3) each attached to
// a behavioural add/sub unit; the SETTLE=1 unit can have a stuck-at fault.
module tb_alu_selftest;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_i  [3];
    logic       ctrl_o   [3];
    logic [3:0] a_o      [3];
    logic [3:0] b_o      [3];
    logic [4:0] resp     [3];
    logic       busy_o   [3];
    logic       done_o   [3];
    logic       pass_o   [3];
    logic [9:0] ecnt_o   [3];
    logic       fv_o     [3];
    logic [8:0] fvec_o   [3];
    logic [4:0] fgot_o   [3];

    int fault = 0;   // 0 none, 1 S[0] stuck-at-0, 2 C0 stuck-at-0 (SETTLE=1 unit only)

    function automatic logic [4:0] unit_resp(input logic ctrl, input logic [3:0] a,
                                             input logic [3:0] b, input int f);
        int r;
        logic c;
        logic [3:0] s;
        if (!ctrl) begin
            r = int'(a) + int'(b);
            s = 4'(r);
            c = (r > 15);
        end else begin
            r = int'(a) - int'(b);
            s = 4'(r);
            c = (a >= b);
        end
        if (f == 1) s[0] = 1'b0;
        if (f == 2) c = 1'b0;
        return {c, s};
    endfunction

    assign resp[0] = unit_resp(ctrl_o[0], a_o[0], b_o[0], 0);
    assign resp[1] = unit_resp(ctrl_o[1], a_o[1], b_o[1], fault);
    assign resp[2] = unit_resp(ctrl_o[2], a_o[2], b_o[2], 0);

    alu_selftest #(.SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start(start_i[0]),
        .dut_ctrl(ctrl_o[0]), .dut_a(a_o[0]), .dut_b(b_o[0]),
        .dut_s(resp[0][3:0]), .dut_c0(resp[0][4]),
        .busy(busy_o[0]), .done(done_o[0]), .pass(pass_o[0]), .err_count(ecnt_o[0]),
        .fail_valid(fv_o[0]), .fail_vec(fvec_o[0]), .fail_got(fgot_o[0]));

    alu_selftest #(.SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(start_i[1]),
        .dut_ctrl(ctrl_o[1]), .dut_a(a_o[1]), .dut_b(b_o[1]),
        .dut_s(resp[1][3:0]), .dut_c0(resp[1][4]),
        .busy(busy_o[1]), .done(done_o[1]), .pass(pass_o[1]), .err_count(ecnt_o[1]),
        .fail_valid(fv_o[1]), .fail_vec(fvec_o[1]), .fail_got(fgot_o[1]));

    alu_selftest #(.SETTLE(3)) u_s3 (
        .clk(clk), .rst(rst), .start(start_i[2]),
        .dut_ctrl(ctrl_o[2]), .dut_a(a_o[2]), .dut_b(b_o[2]),
        .dut_s(resp[2][3:0]), .dut_c0(resp[2][4]),
        .busy(busy_o[2]), .done(done_o[2]), .pass(pass_o[2]), .err_count(ecnt_o[2]),
        .fail_valid(fv_o[2]), .fail_vec(fvec_o[2]), .fail_got(fgot_o[2]));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    // Vector stability: while busy, the driven vector may only change every
    // SETTLE+2 edges (on DRIVE entry).
    int         cyc = 0;
    int         last_chg [3];
    bit         have_chg [3];
    logic [8:0] prev_vec [3];
    int         viol     [3];
    int         period   [3];

    initial begin
        period = '{2, 3, 5};
        for (int k = 0; k < 3; k++) begin
            last_chg[k] = 0; have_chg[k] = 1'b0; prev_vec[k] = '0; viol[k] = 0;
        end
    end

    always @(posedge clk) begin
        logic [8:0] cur;
        cyc++;
        #1;
        for (int k = 0; k < 3; k++) begin
            cur = {a_o[k], b_o[k], ctrl_o[k]};
            if (busy_o[k]) begin
                if (cur != prev_vec[k]) begin
                    if (have_chg[k] && (cyc - last_chg[k]) != period[k]) viol[k]++;
                    last_chg[k] = cyc;
                    have_chg[k] = 1'b1;
                end
            end else begin
                have_chg[k] = 1'b0;
            end
            prev_vec[k] = cur;
        end
    end

    // Pulses start, checks the cleared state right after the start edge, then
    // counts edges up to and including the one that sets done.
    task automatic run_sweep(input int k, input int pulse_at, output int edges);
        int n;
        @(negedge clk);
        start_i[k] = 1'b1;
        @(posedge clk);
        #1;
        start_i[k] = 1'b0;
        chk("start_busy", busy_o[k], 1);
        chk("start_done", done_o[k], 0);
        chk("start_err",  ecnt_o[k], 0);
        chk("start_fv",   fv_o[k],   0);
        n = 0;
        while (!done_o[k] && n < 4000) begin
            @(posedge clk);
            n++;
            #1;
            start_i[k] = (n == pulse_at);
        end
        start_i[k] = 1'b0;
        edges = n;
    endtask

    task automatic check_zero(input int k);
        chk("rst_ctrl", ctrl_o[k], 0);
        chk("rst_a",    a_o[k],    0);
        chk("rst_b",    b_o[k],    0);
        chk("rst_busy", busy_o[k], 0);
        chk("rst_done", done_o[k], 0);
        chk("rst_pass", pass_o[k], 0);
        chk("rst_err",  ecnt_o[k], 0);
        chk("rst_fv",   fv_o[k],   0);
        chk("rst_fvec", fvec_o[k], 0);
        chk("rst_fgot", fgot_o[k], 0);
    endtask

    typedef struct {
        int fault;
        int err;
        int fvld;
        int fvec;
        int fgot;
        int pass;
    } vec_t;

    vec_t tv [4];

    initial begin
        int n;
        tv[0] = '{0,   0, 0, 0, 0, 1};
        tv[1] = '{1, 256, 1, 2, 0, 0};   // first S[0]=1 is A=0,B=1,add
        tv[2] = '{2, 256, 1, 1, 0, 0};   // 120 add carries + 136 sub no-borrow
        tv[3] = '{0,   0, 0, 0, 0, 1};

        rst = 1'b1;
        for (int k = 0; k < 3; k++) start_i[k] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero(1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            fault = tv[i].fault;
            run_sweep(1, -1, n);
            chk("sweep_edges", n, 1536);
            chk("sweep_done",  done_o[1], 1);
            chk("sweep_busy",  busy_o[1], 0);
            chk("sweep_err",   ecnt_o[1], tv[i].err);
            chk("sweep_fv",    fv_o[1],   tv[i].fvld);
            chk("sweep_fvec",  fvec_o[1], tv[i].fvec);
            chk("sweep_fgot",  fgot_o[1], tv[i].fgot);
            chk("sweep_pass",  pass_o[1], tv[i].pass);
            chk("done_vec",    {a_o[1], b_o[1], ctrl_o[1]}, 511);
        end
        fault = 0;

        run_sweep(0, -1, n);
        chk("s0_edges", n, 1024);
        chk("s0_pass",  pass_o[0], 1);
        chk("s0_err",   ecnt_o[0], 0);
        run_sweep(2, -1, n);
        chk("s3_edges", n, 2560);
        chk("s3_pass",  pass_o[2], 1);
        chk("s3_vec",   {a_o[2], b_o[2], ctrl_o[2]}, 511);

        run_sweep(1, 50, n);
        chk("busy_start_edges", n, 1536);
        chk("busy_start_pass",  pass_o[1], 1);

        // Reset in the middle of a sweep, with start also high to show rst wins.
        @(negedge clk);
        start_i[1] = 1'b1;
        @(posedge clk);
        #1;
        start_i[1] = 1'b0;
        n = 0;
        while ({a_o[1], b_o[1], ctrl_o[1]} != 9'd100 && n < 2000) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("reach_v100", {a_o[1], b_o[1], ctrl_o[1]}, 100);
        @(negedge clk);
        rst = 1'b1;
        start_i[1] = 1'b1;
        @(posedge clk);
        #1;
        check_zero(1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_i[1] = 1'b0;
        chk("post_rst_busy", busy_o[1], 1);
        n = 0;
        while (!done_o[1] && n < 4000) begin
            @(posedge clk);
            n++;
            #1;
        end
        chk("restart_edges", n, 1536);
        chk("restart_pass",  pass_o[1], 1);
        chk("restart_err",   ecnt_o[1], 0);

        chk("stable_s0", viol[0], 0);
        chk("stable_s1", viol[1], 0);
        chk("stable_s3", viol[2], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
